// File: rtl/ysyx_220066_wb_arb.sv
`default_nettype none
// ============================================================================
// Module  : ysyx_220066_wb_arb
// Brief   : Write-back arbiter that merges NCH producer channels into one
//           registered regfile write port and commit report. It uses
//           round-robin or fixed-priority grant. Optional per-channel commit
//           counters are built when YSYX_220066_WB_PERF_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
module ysyx_220066_wb_arb #(
    parameter int NCH  = 3,
    parameter int XLEN = 64,
    parameter int RR   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    input  logic [NCH-1:0]       in_wen,
    input  logic [5*NCH-1:0]     in_rd,
    input  logic [XLEN*NCH-1:0]  in_data,
    input  logic [XLEN*NCH-1:0]  in_nxtpc,
    input  logic [NCH-1:0]       in_error,
    input  logic [NCH-1:0]       in_done,
    input  logic                 stall,
`ifdef YSYX_220066_WB_PERF_EN
    output logic [32*NCH-1:0]    perf_cnt,
`endif
    output logic                 wen,
    output logic [4:0]           rd,
    output logic [XLEN-1:0]      data,
    output logic                 out_valid,
    output logic [XLEN-1:0]      pc_nxt,
    output logic                 error,
    output logic                 done
);

    localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [0:0] S_RUN  = 1'b0;
    localparam logic [0:0] S_HALT = 1'b1;

    logic [0:0]      state;
    logic [0:0]      state_nxt;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   ptr_nxt;
    logic [PW-1:0]   start;
    logic [PW-1:0]   gidx;
    logic [NCH-1:0]  grant;
    logic            found;
    logic            active;
    logic            xfer;

    logic            sel_wen;
    logic [4:0]      sel_rd;
    logic [XLEN-1:0] sel_data;
    logic [XLEN-1:0] sel_pc;
    logic            sel_err;
    logic            sel_done;

    // First valid channel at or after the start point, wrapping at NCH.
    always_comb begin
        int j;
        grant = '0;
        gidx  = '0;
        found = 1'b0;
        start = (RR != 0) ? ptr : '0;
        for (int i = 0; i < NCH; i++) begin
            j = int'(start) + i;
            if (j >= NCH) j = j - NCH;
            if (!found && in_valid[j]) begin
                grant[j] = 1'b1;
                gidx     = PW'(j);
                found    = 1'b1;
            end
        end
    end

    always_comb begin
        sel_wen  = 1'b0;
        sel_rd   = '0;
        sel_data = '0;
        sel_pc   = '0;
        sel_err  = 1'b0;
        sel_done = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            if (gidx == PW'(k)) begin
                sel_wen  = in_wen[k];
                sel_rd   = in_rd[5*k +: 5];
                sel_data = in_data[XLEN*k +: XLEN];
                sel_pc   = in_nxtpc[XLEN*k +: XLEN];
                sel_err  = in_error[k];
                sel_done = in_done[k];
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_RUN;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        if (state == S_RUN && xfer && sel_done) begin
            state_nxt = S_HALT;
        end
        if (RR != 0 && xfer) begin
            ptr_nxt = (gidx == PW'(NCH - 1)) ? '0 : gidx + PW'(1);
        end
    end

    // Output logic; the reset term keeps in_ready low while rst is asserted.
    always_comb begin
        active   = (state == S_RUN) && !stall && rst;
        xfer     = active && found;
        in_ready = active ? grant : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            wen       <= 1'b0;
            rd        <= '0;
            data      <= '0;
            pc_nxt    <= '0;
            error     <= 1'b0;
            done      <= 1'b0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            wen       <= sel_wen && (sel_rd != 5'd0);
            rd        <= sel_rd;
            data      <= sel_data;
            pc_nxt    <= sel_pc;
            error     <= sel_err;
            done      <= sel_done;
        end else begin
            out_valid <= 1'b0;
            wen       <= 1'b0;
            error     <= 1'b0;
            done      <= 1'b0;
        end
    end

`ifdef YSYX_220066_WB_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_cnt <= '0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (xfer && grant[k]) begin
                    perf_cnt[32*k +: 32] <= perf_cnt[32*k +: 32] + 32'd1;
                end
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ysyx_220066_wb_arb.sv
`default_nettype none
// ============================================================================
// Module  : tb_ysyx_220066_wb_arb
// Brief   : Self-checking bench; one round-robin and one fixed-priority arbiter
//           are driven in parallel and compared against a behavioural model.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ysyx_220066_wb_arb;

    localparam int NCH  = 3;
    localparam int XLEN = 64;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [NCH-1:0]      in_valid = '0;
    logic [NCH-1:0]      in_wen = '0;
    logic [5*NCH-1:0]    in_rd = '0;
    logic [XLEN*NCH-1:0] in_data = '0;
    logic [XLEN*NCH-1:0] in_nxtpc = '0;
    logic [NCH-1:0]      in_error = '0;
    logic [NCH-1:0]      in_done = '0;
    logic                stall = 1'b0;

    logic [NCH-1:0]  rdy [2];
    logic            ov  [2];
    logic            wo  [2];
    logic [4:0]      rdo [2];
    logic [XLEN-1:0] dto [2];
    logic [XLEN-1:0] pco [2];
    logic            eo  [2];
    logic            dn  [2];
`ifdef YSYX_220066_WB_PERF_EN
    logic [32*NCH-1:0] pf [2];
`endif

    int checks   = 0;
    int failures = 0;

    // Behavioural model state; index 0 = round-robin DUT, 1 = fixed priority.
    int              m_ptr;
    bit              m_halt [2];
    bit              e_v [2];
    bit              e_w [2];
    bit              e_e [2];
    bit              e_d [2];
    logic [4:0]      e_rd [2];
    logic [XLEN-1:0] e_dt [2];
    logic [XLEN-1:0] e_pc [2];
    int unsigned     m_cnt [2][NCH];

    always #5 clk = ~clk;

    ysyx_220066_wb_arb #(.NCH(NCH), .XLEN(XLEN), .RR(1)) dut_rr (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]),
        .in_wen(in_wen), .in_rd(in_rd), .in_data(in_data), .in_nxtpc(in_nxtpc),
        .in_error(in_error), .in_done(in_done), .stall(stall),
`ifdef YSYX_220066_WB_PERF_EN
        .perf_cnt(pf[0]),
`endif
        .wen(wo[0]), .rd(rdo[0]), .data(dto[0]), .out_valid(ov[0]),
        .pc_nxt(pco[0]), .error(eo[0]), .done(dn[0])
    );

    ysyx_220066_wb_arb #(.NCH(NCH), .XLEN(XLEN), .RR(0)) dut_fp (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]),
        .in_wen(in_wen), .in_rd(in_rd), .in_data(in_data), .in_nxtpc(in_nxtpc),
        .in_error(in_error), .in_done(in_done), .stall(stall),
`ifdef YSYX_220066_WB_PERF_EN
        .perf_cnt(pf[1]),
`endif
        .wen(wo[1]), .rd(rdo[1]), .data(dto[1]), .out_valid(ov[1]),
        .pc_nxt(pco[1]), .error(eo[1]), .done(dn[1])
    );

    function automatic int pick(int d);
        int s;
        if (!rst || stall || m_halt[d]) return -1;
        s = (d == 0) ? m_ptr : 0;
        for (int i = 0; i < NCH; i++) begin
            if (in_valid[(s + i) % NCH]) return (s + i) % NCH;
        end
        return -1;
    endfunction

    function automatic logic [NCH-1:0] exp_ready(int d);
        int g;
        logic [NCH-1:0] one;
        g = pick(d);
        one = 1;
        return (g < 0) ? '0 : (one << g);
    endfunction

    task automatic model_reset();
        m_ptr = 0;
        for (int d = 0; d < 2; d++) begin
            m_halt[d] = 0; e_v[d] = 0; e_w[d] = 0; e_e[d] = 0; e_d[d] = 0;
            e_rd[d] = '0; e_dt[d] = '0; e_pc[d] = '0;
            for (int k = 0; k < NCH; k++) m_cnt[d][k] = 0;
        end
    endtask

    task automatic model_tick();
        int g [2];
        for (int d = 0; d < 2; d++) g[d] = pick(d);
        for (int d = 0; d < 2; d++) begin
            if (g[d] >= 0) begin
                e_v[d]  = 1;
                e_rd[d] = in_rd[5*g[d] +: 5];
                e_w[d]  = in_wen[g[d]] && (e_rd[d] != 0);
                e_dt[d] = in_data[XLEN*g[d] +: XLEN];
                e_pc[d] = in_nxtpc[XLEN*g[d] +: XLEN];
                e_e[d]  = in_error[g[d]];
                e_d[d]  = in_done[g[d]];
                if (in_done[g[d]]) m_halt[d] = 1;
                m_cnt[d][g[d]]++;
                if (d == 0) m_ptr = (g[d] + 1) % NCH;
            end else begin
                e_v[d] = 0; e_w[d] = 0; e_e[d] = 0; e_d[d] = 0;
            end
        end
    endtask

    // Clock one edge through model and DUTs; ends 1 ns after posedge.
    task automatic advance();
        model_tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        in_valid = '0; in_wen = '0; in_rd = '0; in_data = '0;
        in_nxtpc = '0; in_error = '0; in_done = '0; stall = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        set_idle();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        model_reset();
        in_valid = '1;
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (rdy[d] !== '0 || ov[d] !== 1'b0 || wo[d] !== 1'b0 || rdo[d] !== '0 ||
                dto[d] !== '0 || pco[d] !== '0 || eo[d] !== 1'b0 || dn[d] !== 1'b0) begin
                failures++;
                $display("FAIL reset_state dut%0d: ready=%b v=%b w=%b rd=%0d data=%h pc=%h err=%b done=%b, want all zero",
                         d, rdy[d], ov[d], wo[d], rdo[d], dto[d], pco[d], eo[d], dn[d]);
            end
        end
        advance();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (ov[d] !== 1'b0) begin
                failures++;
                $display("FAIL reset_no_pulse dut%0d: out_valid=%b want 0", d, ov[d]);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        set_idle();
    endtask

    task automatic test_rr_order();
        logic [NCH-1:0] one;
        one = 1;
        @(negedge clk);
        in_valid = '1;
        in_wen = '1;
        for (int k = 0; k < NCH; k++) in_rd[5*k +: 5] = 5'(k + 10);
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++;
            if (rdy[0] !== (one << (i % 3)) || rdy[1] !== 3'b001) begin
                failures++;
                $display("FAIL rr_order step%0d: rr ready=%b fp ready=%b want %b / 001",
                         i, rdy[0], rdy[1], one << (i % 3));
            end
            advance();
            checks++;
            if (ov[0] !== 1'b1 || rdo[0] !== 5'(10 + i % 3) || wo[0] !== 1'b1) begin
                failures++;
                $display("FAIL rr_pulse step%0d: v=%b rd=%0d w=%b want v=1 rd=%0d w=1",
                         i, ov[0], rdo[0], wo[0], 10 + i % 3);
            end
            @(negedge clk);
        end
        in_valid = '0;
        advance();
        checks++;
        if (ov[0] !== 1'b0 || ov[1] !== 1'b0 || wo[0] !== 1'b0 || rdo[0] !== 5'd12) begin
            failures++;
            $display("FAIL rr_idle: v=%b/%b w=%b rd=%0d want v=0/0 w=0 rd=12 held",
                     ov[0], ov[1], wo[0], rdo[0]);
        end
        @(negedge clk);
    endtask

    task automatic test_fixed_prio();
        in_valid = 3'b110;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (rdy[1] !== 3'b010 || rdy[0] !== exp_ready(0)) begin
                failures++;
                $display("FAIL fixed_prio step%0d: fp ready=%b rr ready=%b want 010 / %b",
                         i, rdy[1], rdy[0], exp_ready(0));
            end
            advance();
            checks++;
            if (ov[1] !== 1'b1 || rdo[1] !== 5'd11 || ov[0] !== 1'b1 || rdo[0] !== e_rd[0]) begin
                failures++;
                $display("FAIL fixed_prio_out step%0d: fp v=%b rd=%0d rr v=%b rd=%0d want 1/11 1/%0d",
                         i, ov[1], rdo[1], ov[0], rdo[0], e_rd[0]);
            end
            @(negedge clk);
        end
        set_idle();
    endtask

    task automatic test_x0_suppress();
        in_valid = 3'b001; in_wen = 3'b001;
        in_rd[4:0] = 5'd0; in_data[XLEN-1:0] = 64'h1234;
        advance();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (ov[d] !== 1'b1 || wo[d] !== 1'b0 || rdo[d] !== 5'd0 || dto[d] !== 64'h1234) begin
                failures++;
                $display("FAIL x0_write dut%0d: v=%b w=%b rd=%0d data=%h want 1 0 0 1234",
                         d, ov[d], wo[d], rdo[d], dto[d]);
            end
        end
        @(negedge clk);
        in_valid = 3'b010; in_wen = 3'b010;
        in_rd[9:5] = 5'd5; in_data[2*XLEN-1:XLEN] = 64'hDEAD;
        advance();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (ov[d] !== 1'b1 || wo[d] !== 1'b1 || rdo[d] !== 5'd5 || dto[d] !== 64'hDEAD) begin
                failures++;
                $display("FAIL rd5_write dut%0d: v=%b w=%b rd=%0d data=%h want 1 1 5 dead",
                         d, ov[d], wo[d], rdo[d], dto[d]);
            end
        end
        @(negedge clk);
        set_idle();
        advance();
        checks++;
        if (ov[0] !== 1'b0 || wo[0] !== 1'b0 || rdo[0] !== 5'd5 || dto[0] !== 64'hDEAD) begin
            failures++;
            $display("FAIL hold_after_x0: v=%b w=%b rd=%0d data=%h want 0 0 5 dead",
                     ov[0], wo[0], rdo[0], dto[0]);
        end
        @(negedge clk);
    endtask

    task automatic test_stall();
        in_valid = 3'b001; stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (rdy[0] !== '0 || rdy[1] !== '0) begin
                failures++;
                $display("FAIL stall_ready cyc%0d: ready=%b/%b want 000", i, rdy[0], rdy[1]);
            end
            advance();
            checks++;
            if (ov[0] !== 1'b0 || ov[1] !== 1'b0) begin
                failures++;
                $display("FAIL stall_pulse cyc%0d: v=%b/%b want 0", i, ov[0], ov[1]);
            end
            @(negedge clk);
        end
        stall = 1'b0;
        #1;
        checks++;
        if (rdy[0] !== 3'b001 || rdy[1] !== 3'b001) begin
            failures++;
            $display("FAIL unstall_ready: ready=%b/%b want 001", rdy[0], rdy[1]);
        end
        advance();
        checks++;
        if (ov[0] !== 1'b1 || ov[1] !== 1'b1) begin
            failures++;
            $display("FAIL unstall_pulse: v=%b/%b want 1", ov[0], ov[1]);
        end
        @(negedge clk);
        set_idle();
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            in_valid = NCH'($urandom);
            in_wen   = NCH'($urandom);
            in_error = NCH'($urandom);
            in_done  = '0;
            stall    = ($urandom_range(0, 3) == 0);
            for (int k = 0; k < NCH; k++) begin
                in_rd[5*k +: 5] = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
                in_data[XLEN*k +: XLEN]  = {$urandom, $urandom};
                in_nxtpc[XLEN*k +: XLEN] = {$urandom, $urandom};
            end
            #1;
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (rdy[d] !== exp_ready(d)) begin
                    failures++;
                    $display("FAIL rand_ready dut%0d cyc%0d: ready=%b want %b", d, c, rdy[d], exp_ready(d));
                end
            end
            advance();
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (ov[d] !== e_v[d] || wo[d] !== e_w[d] || rdo[d] !== e_rd[d] || dto[d] !== e_dt[d] ||
                    pco[d] !== e_pc[d] || eo[d] !== e_e[d] || dn[d] !== e_d[d]) begin
                    failures++;
                    $display("FAIL rand_out dut%0d cyc%0d: v=%b w=%b rd=%0d data=%h pc=%h err=%b done=%b want %b %b %0d %h %h %b %b",
                             d, c, ov[d], wo[d], rdo[d], dto[d], pco[d], eo[d], dn[d],
                             e_v[d], e_w[d], e_rd[d], e_dt[d], e_pc[d], e_e[d], e_d[d]);
                end
            end
            @(negedge clk);
        end
        set_idle();
`ifdef YSYX_220066_WB_PERF_EN
        #1;
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < NCH; k++) begin
                checks++;
                if (pf[d][32*k +: 32] !== m_cnt[d][k]) begin
                    failures++;
                    $display("FAIL rand_perf dut%0d ch%0d: count=%0d want %0d",
                             d, k, pf[d][32*k +: 32], m_cnt[d][k]);
                end
            end
        end
`endif
    endtask

`ifdef YSYX_220066_WB_PERF_EN
    task automatic test_perf();
        apply_reset();
        in_valid = 3'b010;
        for (int i = 0; i < 5; i++) begin
            advance();
            @(negedge clk);
        end
        set_idle();
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (pf[d][63:32] !== 32'd5 || pf[d][31:0] !== 32'd0) begin
                failures++;
                $display("FAIL perf_count dut%0d: ch1=%0d ch0=%0d want 5 0", d, pf[d][63:32], pf[d][31:0]);
            end
        end
        rst = 1'b0;
        model_reset();
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (pf[d] !== '0) begin
                failures++;
                $display("FAIL perf_async_clear dut%0d: perf=%h want 0", d, pf[d]);
            end
        end
        @(negedge clk);
        rst = 1'b1;
    endtask
`endif

    task automatic test_halt();
        apply_reset();
        in_valid = 3'b100; in_done = 3'b100;
        in_nxtpc[3*XLEN-1:2*XLEN] = 64'h8000_0010;
        advance();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (ov[d] !== 1'b1 || dn[d] !== 1'b1 || pco[d] !== 64'h8000_0010) begin
                failures++;
                $display("FAIL halt_pulse dut%0d: v=%b done=%b pc=%h want 1 1 80000010", d, ov[d], dn[d], pco[d]);
            end
        end
        @(negedge clk);
        in_valid = 3'b111; in_done = '0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (rdy[0] !== '0 || rdy[1] !== '0) begin
                failures++;
                $display("FAIL halt_ready cyc%0d: ready=%b/%b want 000", i, rdy[0], rdy[1]);
            end
            advance();
            checks++;
            if (ov[0] !== 1'b0 || dn[0] !== 1'b0 || ov[1] !== 1'b0 || dn[1] !== 1'b0) begin
                failures++;
                $display("FAIL halt_quiet cyc%0d: v=%b/%b done=%b/%b want 0", i, ov[0], ov[1], dn[0], dn[1]);
            end
            @(negedge clk);
        end
        rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if (pco[0] !== '0 || rdy[0] !== '0) begin
            failures++;
            $display("FAIL async_reset: pc=%h ready=%b want 0 000", pco[0], rdy[0]);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (rdy[0] !== 3'b001 || rdy[1] !== 3'b001) begin
            failures++;
            $display("FAIL resume_ready: ready=%b/%b want 001", rdy[0], rdy[1]);
        end
        in_rd[4:0] = 5'd7;
        advance();
        checks++;
        if (ov[0] !== 1'b1 || rdo[0] !== 5'd7) begin
            failures++;
            $display("FAIL resume_pulse: v=%b rd=%0d want 1 7", ov[0], rdo[0]);
        end
        @(negedge clk);
        set_idle();
    endtask

    initial begin
        test_reset();
        test_rr_order();
        test_fixed_prio();
        test_x0_suppress();
        test_stall();
        test_random();
`ifdef YSYX_220066_WB_PERF_EN
        test_perf();
`endif
        test_halt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded 200000 ns");
        $fatal(1);
    end

endmodule
`default_nettype wire
